// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
//   Shared types and helpers for the data-memory responder and its lane
//   alignment logic.
//   Contents:
//     mem_state_t  - responder FSM states (IDLE, WAIT, RESP)
//     SZ_*         - RV32I load/store funct3 size encodings
//     legal_req()  - size and alignment legality of a request
// ----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Checks the size encoding and the natural alignment of the access.
    // Only the byte offset matters here; the range check depends on the
    // memory depth and is therefore done by the instantiating module.
    // Unsigned sizes only make sense for loads, so stores with them are
    // rejected.
    function automatic logic legal_req(input logic       we,
                                       input logic [2:0] size,
                                       input logic [1:0] addr_off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_BU:   ok = !we;
            SZ_H:    ok = (addr_off[0] == 1'b0);
            SZ_HU:   ok = !we && (addr_off[0] == 1'b0);
            SZ_W:    ok = (addr_off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// ----------------------------------------------------------------------------
// lane_align
//   Purely combinational byte-lane logic shared between memory-side blocks.
//   Store side: byte enables plus write data replicated across the lanes.
//   Load side : selects the addressed byte/half/word from a memory word and
//               sign- or zero-extends it to 32 bits.
//   Ports:
//     addr_off_i   [1:0]  byte offset inside the word (addr[1:0])
//     size_i       [2:0]  funct3 size encoding
//     wdata_i      [31:0] store data, value taken from the low bits for b/h
//     rword_i      [31:0] word read from memory
//     be_o         [3:0]  store byte enables
//     wdata_rep_o  [31:0] store data replicated to all lanes
//     rdata_ext_o  [31:0] extended load data
// ----------------------------------------------------------------------------
module lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_off_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o
);

    logic [31:0] shifted;

    // Store path: replicate the value so that whichever lane is enabled
    // already carries the right bytes; the enables pick the lanes.
    always_comb begin
        be_o        = 4'b0000;
        wdata_rep_o = wdata_i;
        case (size_i)
            SZ_B: begin
                be_o        = 4'(4'b0001 << addr_off_i);
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o        = 4'(4'b0011 << addr_off_i);
                wdata_rep_o = {2{wdata_i[15:0]}};
            end
            SZ_W: begin
                be_o        = 4'b1111;
                wdata_rep_o = wdata_i;
            end
            default: begin
                be_o        = 4'b0000;
                wdata_rep_o = wdata_i;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0 first, then extend.
    always_comb begin
        shifted     = rword_i >> {addr_off_i, 3'b000};
        rdata_ext_o = 32'h0;
        case (size_i)
            SZ_B:    rdata_ext_o = {{24{shifted[7]}}, shifted[7:0]};
            SZ_BU:   rdata_ext_o = {24'h0, shifted[7:0]};
            SZ_H:    rdata_ext_o = {{16{shifted[15]}}, shifted[15:0]};
            SZ_HU:   rdata_ext_o = {16'h0, shifted[15:0]};
            SZ_W:    rdata_ext_o = shifted;
            default: rdata_ext_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Multi-cycle data-memory responder for the RV32I core load/store port.
//   Accepts one request at a time, answers LATENCY cycles after the accept
//   edge with a one-cycle resp_valid_o pulse, applies byte lanes on stores and
//   returns extended load data. The core stalls its PC on resp_valid_o, so
//   this block sets the stall length.
//   Parameters:
//     DEPTH_WORDS  words of storage (byte addresses 0 .. 4*DEPTH_WORDS-1)
//     LATENCY      accept edge to resp_valid_o rising edge, >= 1
//   Ports:
//     clk           clock, rising edge
//     reset         asynchronous, active-high
//     req_valid_i   request present
//     req_ready_o   responder idle and able to accept
//     req_we_i      1 = store, 0 = load
//     req_addr_i    byte address
//     req_size_i    funct3 size (b, h, w, bu, hu)
//     req_wdata_i   store data
//     resp_valid_o  one-cycle response pulse
//     resp_rdata_o  extended load data, 0 for stores and errors
//     resp_err_o    illegal size, misaligned or out-of-range request
// ----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Named in capitals so test benches can preload it directly.
    logic [31:0] RAM [DEPTH_WORDS-1:0];

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic          accept_err;
    logic          commit;
    logic [AW-1:0] word_idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   rdata_ext;

    // Error classification is done once at accept and carried along, so the
    // request registers only have to be trusted on the accept edge.
    always_comb begin
        accept_err = !legal_req(req_we_i, req_size_i, req_addr_i[1:0]) ||
                     (req_addr_i[31:2] >= 30'(DEPTH_WORDS));
    end

    // The index is truncated to the array width; out-of-range requests are
    // flagged as errors, so neither a write nor the read data is ever used.
    assign word_idx = addr_q[AW+1:2];
    assign rword    = RAM[word_idx];

    lane_align u_lane_align (
        .addr_off_i  (addr_q[1:0]),
        .size_i      (size_q),
        .wdata_i     (wdata_q),
        .rword_i     (rword),
        .be_o        (be),
        .wdata_rep_o (wdata_rep),
        .rdata_ext_o (rdata_ext)
    );

    // Next-state and registered-output logic. The edge that leaves WAIT is
    // the commit point: the store lands in RAM and the load data is captured
    // in the same edge that raises resp_valid.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        commit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d         = req_we_i;
                    addr_d       = req_addr_i;
                    size_d       = req_size_i;
                    wdata_d      = req_wdata_i;
                    err_d        = accept_err;
                    cnt_d        = CW'(LATENCY - 1);
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = (err_q || we_q) ? 32'h0 : rdata_ext;
                    commit       = we_q && !err_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers. Reset abandons any request in flight; an
    // uncommitted store simply never reaches the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            size_q       <= 3'b000;
            wdata_q      <= 32'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage has no reset so that its contents survive a core reset.
    // Only the enabled lanes are written.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    RAM[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule
